// File: rtl/fechadura_pkg.sv
// Shared types and helpers for the door-lock system: lock FSM states,
// bundled PIN-result pulses and setup values, and the time clamp.
package fechadura_pkg;

   localparam logic [6:0] TEMPO_MIN = 7'd5;
   localparam logic [6:0] TEMPO_MAX = 7'd60;

   typedef enum logic [2:0] {
      TRAVADA,
      BLOQUEIO,
      DESTRAVADA,
      PORTA_ABERTA,
      SETUP,
      TROCA_MASTER
   } estado_tranca_t;

   typedef struct packed {
      logic pin;
      logic master;
      logic padrao;
      logic master_update;
      logic fail;
   } pinPac_t;

   typedef struct packed {
      logic       bip_status;
      logic [6:0] bip_time;
      logic [6:0] tranca_aut_time;
      logic       done;
   } setupPac_t;

   function automatic logic [6:0] clamp_tempo(input logic [6:0] t);
      return (t < TEMPO_MIN) ? TEMPO_MIN : ((t > TEMPO_MAX) ? TEMPO_MAX : t);
   endfunction

endpackage

// File: rtl/gerador_tick.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1, pulses tick on the last
// count, and can be restarted synchronously so a fresh second starts at once.
module gerador_tick #(
   parameter int TICKS_PER_SEC = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart || tick) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/controle_tranca.sv
// Door-lock sequencer: owns the bolt, failed-attempt lockout, door-open
// beeper, auto-relock timer and entry into setup / master-PIN change.
module controle_tranca
   import fechadura_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100_000_000,
   parameter int MAX_FAILS     = 3,
   parameter int LOCKOUT_S     = 30
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           senha_pin,
   input  logic           senha_master,
   input  logic           senha_padrao,
   input  logic           senha_master_update,
   input  logic           senha_fail,
   input  logic           setup_done,
   input  logic           sensor_porta,
   input  logic           botao_interno,
   input  logic           bip_status,
   input  logic [6:0]     bip_time,
   input  logic [6:0]     tranca_aut_time,
   output logic           tranca,
   output logic           bip,
   output logic           bloqueado,
   output logic           setup_on,
   output logic           troca_master,
   output logic           clear_pin,
   output estado_tranca_t estado_dbg
);

   localparam int FW = (MAX_FAILS > 1) ? $clog2(MAX_FAILS) : 1;
   localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
   localparam logic [6:0]    LOCK_LIM  = 7'(LOCKOUT_S);

   pinPac_t   pulsos;
   setupPac_t cfg;
   assign pulsos = {senha_pin, senha_master, senha_padrao, senha_master_update, senha_fail};
   assign cfg    = {bip_status, bip_time, tranca_aut_time, setup_done};

   estado_tranca_t state_q, state_d;
   logic [FW-1:0]  fails_q, fails_d;
   logic [6:0]     secs_q, secs_d, secs_adv;
   logic [6:0]     lim_q, lim_d;
   logic           tranca_q, tranca_d, bip_q, bip_d, bloqueado_q, bloqueado_d;
   logic           setup_on_q, setup_on_d, troca_master_q, troca_master_d;
   logic           clear_pin_q, clear_pin_d;
   logic           tick, change;

   gerador_tick #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (change),
      .tick    (tick)
   );

   always_comb begin
      state_d  = state_q;
      fails_d  = fails_q;
      lim_d    = lim_q;
      // Seconds counter saturates rather than wrapping.
      secs_adv = (tick && secs_q != 7'd127) ? secs_q + 7'd1 : secs_q;

      case (state_q)
         TRAVADA: begin
            if (pulsos.padrao)                   state_d = TROCA_MASTER;
            else if (pulsos.master)              state_d = SETUP;
            else if (pulsos.pin || botao_interno) begin
               state_d = DESTRAVADA;
               fails_d = '0;
            end else if (pulsos.fail) begin
               if (fails_q >= FAIL_LAST) state_d = BLOQUEIO;
               else                      fails_d = fails_q + FW'(1);
            end
         end
         BLOQUEIO: begin
            // Leave one attempt short of the limit so a single fail re-locks.
            if (secs_adv >= LOCK_LIM) begin
               state_d = TRAVADA;
               fails_d = FAIL_LAST;
            end
         end
         DESTRAVADA: begin
            if (sensor_porta)                               state_d = PORTA_ABERTA;
            else if (botao_interno || secs_adv >= lim_q)    state_d = TRAVADA;
         end
         PORTA_ABERTA: if (!sensor_porta)        state_d = DESTRAVADA;
         SETUP:        if (cfg.done)             state_d = TRAVADA;
         TROCA_MASTER: if (pulsos.master_update) state_d = TRAVADA;
         default:                                state_d = TRAVADA;
      endcase

      change = (state_d != state_q);
      secs_d = change ? 7'd0 : secs_adv;
      if (change)
         lim_d = (state_d == PORTA_ABERTA) ? clamp_tempo(cfg.bip_time)
                                           : clamp_tempo(cfg.tranca_aut_time);

      tranca_d       = !(state_d == DESTRAVADA || state_d == PORTA_ABERTA);
      bip_d          = (state_d == PORTA_ABERTA) && cfg.bip_status && (secs_d >= lim_d);
      bloqueado_d    = (state_d == BLOQUEIO);
      setup_on_d     = (state_d == SETUP);
      troca_master_d = (state_d == TROCA_MASTER);
      clear_pin_d    = change || pulsos.fail;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= TRAVADA;
         fails_q        <= '0;
         secs_q         <= '0;
         lim_q          <= '0;
         tranca_q       <= 1'b1;
         bip_q          <= 1'b0;
         bloqueado_q    <= 1'b0;
         setup_on_q     <= 1'b0;
         troca_master_q <= 1'b0;
         clear_pin_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         fails_q        <= fails_d;
         secs_q         <= secs_d;
         lim_q          <= lim_d;
         tranca_q       <= tranca_d;
         bip_q          <= bip_d;
         bloqueado_q    <= bloqueado_d;
         setup_on_q     <= setup_on_d;
         troca_master_q <= troca_master_d;
         clear_pin_q    <= clear_pin_d;
      end
   end

   assign tranca       = tranca_q;
   assign bip          = bip_q;
   assign bloqueado    = bloqueado_q;
   assign setup_on     = setup_on_q;
   assign troca_master = troca_master_q;
   assign clear_pin    = clear_pin_q;
   assign estado_dbg   = state_q;

endmodule

// File: tb/tb_controle_tranca.sv
// Bench for controle_tranca: cycle-count reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_controle_tranca;
   import fechadura_pkg::*;

   localparam int T  = 10;
   localparam int MF = 3;
   localparam int LS = 30;

   localparam logic [6:0] P_PIN    = 7'd1;
   localparam logic [6:0] P_MASTER = 7'd2;
   localparam logic [6:0] P_PADRAO = 7'd4;
   localparam logic [6:0] P_UPD    = 7'd8;
   localparam logic [6:0] P_FAIL   = 7'd16;
   localparam logic [6:0] P_SDONE  = 7'd32;
   localparam logic [6:0] P_BOTAO  = 7'd64;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       senha_pin = 1'b0, senha_master = 1'b0, senha_padrao = 1'b0;
   logic       senha_master_update = 1'b0, senha_fail = 1'b0, setup_done = 1'b0;
   logic       sensor_porta = 1'b0, botao_interno = 1'b0, bip_status = 1'b0;
   logic [6:0] bip_time = 7'd5, tranca_aut_time = 7'd5;
   logic       tranca, bip, bloqueado, setup_on, troca_master, clear_pin;
   estado_tranca_t estado_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   controle_tranca #(.TICKS_PER_SEC(T), .MAX_FAILS(MF), .LOCKOUT_S(LS)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .senha_pin           (senha_pin),
      .senha_master        (senha_master),
      .senha_padrao        (senha_padrao),
      .senha_master_update (senha_master_update),
      .senha_fail          (senha_fail),
      .setup_done          (setup_done),
      .sensor_porta        (sensor_porta),
      .botao_interno       (botao_interno),
      .bip_status          (bip_status),
      .bip_time            (bip_time),
      .tranca_aut_time     (tranca_aut_time),
      .tranca              (tranca),
      .bip                 (bip),
      .bloqueado           (bloqueado),
      .setup_on            (setup_on),
      .troca_master        (troca_master),
      .clear_pin           (clear_pin),
      .estado_dbg          (estado_dbg)
   );

   task automatic chk(input string name, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
      end
   endtask

   // reference model: mode plus cycles elapsed since entering it
   localparam int M_TRAV = 0, M_BLOQ = 1, M_DEST = 2, M_ABER = 3, M_SETUP = 4, M_TROCA = 5;
   int   m_mode  = M_TRAV;
   int   m_k     = 0;
   int   m_fails = 0;
   int   m_lim   = 0;
   logic m_clear = 1'b0;
   logic m_bip   = 1'b0;

   function automatic int secs_clamp(input logic [6:0] t);
      return (t < 7'd5) ? 5 : ((t > 7'd60) ? 60 : int'(t));
   endfunction

   task automatic model_reset();
      m_mode = M_TRAV; m_k = 0; m_fails = 0; m_lim = 0; m_clear = 1'b0; m_bip = 1'b0;
   endtask

   task automatic model_step();
      int nx;
      int k;
      nx = m_mode;
      k  = m_k + 1;
      case (m_mode)
         M_TRAV: begin
            if (senha_padrao)                        nx = M_TROCA;
            else if (senha_master)                   nx = M_SETUP;
            else if (senha_pin || botao_interno) begin nx = M_DEST; m_fails = 0; end
            else if (senha_fail) begin
               m_fails++;
               if (m_fails >= MF) nx = M_BLOQ;
            end
         end
         M_BLOQ:  if (k >= LS * T) begin nx = M_TRAV; m_fails = MF - 1; end
         M_DEST: begin
            if (sensor_porta)                        nx = M_ABER;
            else if (botao_interno || k >= m_lim)    nx = M_TRAV;
         end
         M_ABER:  if (!sensor_porta)       nx = M_DEST;
         M_SETUP: if (setup_done)          nx = M_TRAV;
         M_TROCA: if (senha_master_update) nx = M_TRAV;
         default: nx = M_TRAV;
      endcase
      m_clear = (nx != m_mode) || senha_fail;
      if (nx != m_mode) begin
         k     = 0;
         m_lim = ((nx == M_ABER) ? secs_clamp(bip_time) : secs_clamp(tranca_aut_time)) * T;
      end
      m_mode = nx;
      m_k    = k;
      m_bip  = (m_mode == M_ABER) && bip_status && (m_k >= m_lim);
   endtask

   // scoreboard compare, every cycle and on asynchronous reset
   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
      #1;
      chk("cyc_tranca",       tranca,       !(m_mode == M_DEST || m_mode == M_ABER));
      chk("cyc_bip",          bip,          m_bip);
      chk("cyc_bloqueado",    bloqueado,    m_mode == M_BLOQ);
      chk("cyc_setup_on",     setup_on,     m_mode == M_SETUP);
      chk("cyc_troca_master", troca_master, m_mode == M_TROCA);
      chk("cyc_clear_pin",    clear_pin,    m_clear);
   end

   // driver tasks
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [6:0] m);
      @(negedge clk);
      senha_pin           = m[0];
      senha_master        = m[1];
      senha_padrao        = m[2];
      senha_master_update = m[3];
      senha_fail          = m[4];
      setup_done          = m[5];
      botao_interno       = m[6];
      @(negedge clk);
      {senha_pin, senha_master, senha_padrao, senha_master_update} = 4'b0;
      {senha_fail, setup_done, botao_interno} = 3'b0;
   endtask

   initial begin
      wait_cyc(3);
      chk("rst_tranca", tranca, 1'b1);
      chk("rst_bip", bip, 1'b0);
      chk("rst_bloqueado", bloqueado, 1'b0);
      chk("rst_setup_on", setup_on, 1'b0);
      chk("rst_troca_master", troca_master, 1'b0);
      chk("rst_clear_pin", clear_pin, 1'b0);
      rst = 1'b1;
      wait_cyc(2);

      // unlock, auto-relock after 5 s
      pulse(P_PIN);
      chk("pin_unlock", tranca, 1'b0);
      chk("pin_clear", clear_pin, 1'b1);
      wait_cyc(49); chk("relock_c49", tranca, 1'b0);
      wait_cyc(1);  chk("relock_c50", tranca, 1'b1);

      // three fails -> lockout, pin ignored, re-lock on one more fail
      pulse(P_FAIL); chk("fail1_clear", clear_pin, 1'b1); chk("fail1_bloq", bloqueado, 1'b0);
      pulse(P_FAIL); chk("fail2_bloq", bloqueado, 1'b0);
      pulse(P_FAIL); chk("fail3_bloq", bloqueado, 1'b1);
      pulse(P_PIN);  chk("bloq_pin_tranca", tranca, 1'b1); chk("bloq_pin_bloq", bloqueado, 1'b1);
      wait_cyc(297); chk("bloq_c299", bloqueado, 1'b1);
      wait_cyc(1);   chk("bloq_c300", bloqueado, 1'b0); chk("bloq_exit_clear", clear_pin, 1'b1);
      pulse(P_FAIL); chk("refail_bloq", bloqueado, 1'b1);
      wait_cyc(300);
      pulse(P_PIN);   chk("after_bloq_unlock", tranca, 1'b0);
      pulse(P_BOTAO); chk("botao_lock", tranca, 1'b1);

      // door open beeper, clamped times
      pulse(P_PIN);
      bip_status = 1'b1; bip_time = 7'd2; sensor_porta = 1'b1;
      wait_cyc(50); chk("bip_c49", bip, 1'b0); chk("open_tranca", tranca, 1'b0);
      wait_cyc(1);  chk("bip_c50", bip, 1'b1);
      pulse(P_BOTAO); chk("open_botao_tranca", tranca, 1'b0); chk("open_botao_bip", bip, 1'b1);
      tranca_aut_time = 7'd100; sensor_porta = 1'b0;
      wait_cyc(1);   chk("close_bip", bip, 1'b0); chk("close_tranca", tranca, 1'b0);
      wait_cyc(599); chk("relock60_c599", tranca, 1'b0);
      wait_cyc(1);   chk("relock60_c600", tranca, 1'b1);
      tranca_aut_time = 7'd5; bip_status = 1'b0;

      // master wins over fail; fail count preserved
      pulse(P_FAIL);            chk("pre_setup_bloq", bloqueado, 1'b0);
      pulse(P_MASTER | P_FAIL); chk("setup_on", setup_on, 1'b1);
      chk("setup_tranca", tranca, 1'b1); chk("setup_clear", clear_pin, 1'b1);
      pulse(P_SDONE); chk("setup_exit", setup_on, 1'b0); chk("setup_exit_tranca", tranca, 1'b1);
      pulse(P_FAIL);  chk("kept_fail2", bloqueado, 1'b0);
      pulse(P_FAIL);  chk("kept_fail3", bloqueado, 1'b1);
      wait_cyc(300);
      pulse(P_PIN);
      pulse(P_BOTAO);

      // master-PIN change
      pulse(P_PADRAO); chk("troca_on", troca_master, 1'b1); chk("troca_clear", clear_pin, 1'b1);
      wait_cyc(1);     chk("troca_hold", troca_master, 1'b1); chk("troca_clear_low", clear_pin, 1'b0);
      pulse(P_UPD);    chk("troca_off", troca_master, 1'b0); chk("troca_exit_clear", clear_pin, 1'b1);

      // asynchronous reset while beeping
      pulse(P_PIN);
      sensor_porta = 1'b1; bip_status = 1'b1; bip_time = 7'd5;
      wait_cyc(51); chk("pre_rst_bip", bip, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("rst_async_tranca", tranca, 1'b1);
      chk("rst_async_bip", bip, 1'b0);
      sensor_porta = 1'b0; bip_status = 1'b0;
      wait_cyc(2);
      rst = 1'b1;
      wait_cyc(3);
      chk("post_rst_tranca", tranca, 1'b1);
      chk("post_rst_bloq", bloqueado, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
